gray_decoder_monitor: RTL and testbench
=======================================

// Module: gray_decoder_monitor
// PURPOSE
//  Reader side of the gray counter path. Samples an N-bit gray-coded bus from an
//  unrelated domain (counter output / LED bus), synchronizes it, decodes it to
//  binary, and checks every change for a legal single-bit gray step.
//  Reports step direction and wrap-around, and flags illegal multi-bit jumps.
//  Sits on the receive side of the debounced gray counter in the system block.
// PARAMETERS
//  N      8  gray/binary bus width (N >= 2)
//  ERR_W  8  error-counter width; used only when GRAY_ERRCNT_EN is defined
// PORTS
//  clk         in   1      system clock, rising edge
//  reset       in   1      asynchronous, active-low reset
//  clear       in   1      sync clear: restart baseline, clear error state
//  gray_in     in   N      gray-coded input, asynchronous to clk
//  bin_out     out  N      decoded binary of last accepted sample
//  valid       out  1      1-cycle pulse: legal single-step change accepted
//  dir_up      out  1      direction of last legal step: 1=+1, 0=-1 (held)
//  wrap        out  1      1-cycle pulse: legal step crossed 2^N-1 <-> 0
//  step_err    out  1      1-cycle pulse: illegal change (>1 bit flipped)
//  err_sticky  out  1      set by any step_err; cleared by reset or clear
//  err_cnt     out  ERR_W  saturating illegal-step count (GRAY_ERRCNT_EN only)
// BEHAVIOUR
//  - Reset (reset=0): s1, s2, prev_gray, bin_out <= 0; valid, dir_up, wrap,
//    step_err, err_sticky <= 0; err_cnt <= 0; state <= INIT.
//  - Sync: gray_in -> s1 -> s2. Two flops, no logic between them.
//  - Decode: b[N-1] = g[N-1]; b[i] = b[i+1] ^ g[i]. Applied to s2.
//  - Latency: gray_in stable before edge E0 -> s1 @E0, s2 @E1.
//    bin_out/valid/wrap/step_err are registered @E2.
//  - FSM has two states:
//    INIT:  one cycle. prev_gray <= s2; bin_out <= dec(s2); no pulses.
//           Next state: TRACK.
//    TRACK: d = s2 ^ prev_gray.
//      d == 0:         no pulses; outputs hold.
//      popcount(d)==1: valid=1; prev_gray <= s2; bin_out <= dec(s2);
//                      dir_up <= (dec(s2) == bin_out+1 mod 2^N).
//                      wrap=1 if bin_out 2^N-1 -> 0 (up) or 0 -> 2^N-1 (down).
//      popcount(d)>1:  step_err=1, valid=0, wrap=0; err_sticky <= 1;
//                      dir_up holds; prev_gray <= s2; bin_out <= dec(s2)
//                      (resync baseline, no direction inferred).
//  - Pulses (valid, wrap, step_err) are high exactly one cycle per event.
//  - clear (sampled at posedge, priority over TRACK logic):
//    state <= INIT; err_sticky <= 0; err_cnt <= 0; pulses <= 0.
//    bin_out, dir_up hold until INIT reloads. s1/s2 are not cleared.
//  - Async reset mid-operation: immediate return to reset values. First
//    post-reset cycle is INIT; no spurious valid/step_err from that baseline.
//  - Hold time: each gray_in value stays stable >= 2 clk cycles (guaranteed
//    by the debounced counter). Faster input may alias into step_err; legal.
// CONFIGURATION
//  GRAY_ERRCNT_EN defined:
//    err_cnt present; +1 on each step_err, saturates at 2^ERR_W-1.
//    Cleared by reset and by clear.
//  GRAY_ERRCNT_EN undefined:
//    err_cnt port and counter are absent; ERR_W is unused.
//    All other behaviour is identical.
// TESTING (N=8, ERR_W=8, GRAY_ERRCNT_EN defined)
//  1 Reset, gray_in=8'h00 held -> after INIT: bin_out=0, no valid/step_err.
//  2 Drive gray sequence for 0..5, 4 clk each -> valid x5, bin_out=5,
//    dir_up=1, wrap=0. Output change lands 3 edges after each input edge.
//  3 gray 8'h80 (255) -> 8'h00 (0) -> valid=1, wrap=1, dir_up=1.
//    Then 8'h00 -> 8'h80 -> wrap=1, dir_up=0, bin_out=255.
//  4 Jump 8'h01 -> 8'h07 (1 -> 5) -> step_err=1, valid=0, err_sticky=1,
//    err_cnt=1, bin_out=5. Next legal step 8'h07 -> 8'h06 gives valid=1.
//  5 Force 300 illegal jumps -> err_cnt saturates at 255. Then pulse clear
//    -> err_cnt=0, err_sticky=0, one INIT cycle, no valid.
//  6 Assert reset mid-sequence while valid is high -> all outputs 0
//    immediately; after release, baseline reloads, no spurious pulses.

Source files
------------

// File: rtl/gray_decoder_monitor.sv
// Purpose: synchronize an async gray-coded bus, decode to binary, police single-bit steps.
// Latency: input stable before edge E0 -> outputs registered at E2 (3 edges after input change).
// Backpressure: none; free-running monitor, pulses are one cycle per event.
//
// Optional feature macro: GRAY_ERRCNT_EN adds the saturating err_cnt output.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   clear      synchronous clear: restart baseline, drop error state
//   gray_in    N-bit gray input, asynchronous to clk
//   bin_out    decoded binary of last accepted sample
//   valid      pulse: legal single-step change accepted
//   dir_up     held direction of last legal step (1 = +1, 0 = -1)
//   wrap       pulse: legal step crossed all-ones <-> zero
//   step_err   pulse: illegal change (more than one bit flipped)
//   err_sticky set by any step_err, cleared by reset or clear
//   err_cnt    saturating illegal-step count (GRAY_ERRCNT_EN only)
module gray_decoder_monitor #(
  parameter int N     = 8,
  parameter int ERR_W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic [N-1:0] gray_in,
  output logic [N-1:0] bin_out,
  output logic         valid,
  output logic         dir_up,
  output logic         wrap,
  output logic         step_err,
  output logic         err_sticky
`ifdef GRAY_ERRCNT_EN
  ,
  output logic [ERR_W-1:0] err_cnt
`endif
);

  if (N < 2 || ERR_W < 1) begin : g_bad_param
    $error("gray_decoder_monitor: N must be >= 2 and ERR_W >= 1");
  end

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_TRACK = 1'b1
  } state_t;

  localparam logic [N-1:0] ONE  = {{(N-1){1'b0}}, 1'b1};
  localparam logic [N-1:0] ALL1 = {N{1'b1}};

  state_t       state_q;
  logic [N-1:0] s1_q;
  logic [N-1:0] s2_q;
  logic [N-1:0] prev_gray_q;
  logic [N-1:0] bin_q;
  logic         valid_q;
  logic         dir_up_q;
  logic         wrap_q;
  logic         step_err_q;
  logic         err_sticky_q;
  // Counts sync-chain fills after reset; the baseline is only trusted once
  // s2 holds a genuine sample rather than its reset value.
  logic [1:0]   prime_q;

  logic [N-1:0] bin_d;
  logic [N-1:0] diff_d;
  logic         one_bit_d;
  logic         dir_up_d;
  logic         wrap_d;

  // Gray to binary: each binary bit is the XOR of all gray bits at or above it.
  always_comb begin
    bin_d        = '0;
    bin_d[N-1]   = s2_q[N-1];
    for (int i = N - 2; i >= 0; i--) begin
      bin_d[i] = bin_d[i+1] ^ s2_q[i];
    end
  end

  always_comb begin
    diff_d    = s2_q ^ prev_gray_q;
    // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
    one_bit_d = (diff_d != '0) && ((diff_d & (diff_d - ONE)) == '0);
    dir_up_d  = (bin_d == (bin_q + ONE));
    wrap_d    = dir_up_d ? ((bin_q == ALL1) && (bin_d == '0))
                         : ((bin_q == '0) && (bin_d == ALL1));
  end

`ifdef GRAY_ERRCNT_EN
  logic [ERR_W-1:0] err_cnt_q;
  localparam logic [ERR_W-1:0] CNT_MAX = {ERR_W{1'b1}};
  localparam logic [ERR_W-1:0] CNT_ONE = {{(ERR_W-1){1'b0}}, 1'b1};
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_INIT;
      s1_q         <= '0;
      s2_q         <= '0;
      prev_gray_q  <= '0;
      bin_q        <= '0;
      valid_q      <= 1'b0;
      dir_up_q     <= 1'b0;
      wrap_q       <= 1'b0;
      step_err_q   <= 1'b0;
      err_sticky_q <= 1'b0;
      prime_q      <= 2'd0;
`ifdef GRAY_ERRCNT_EN
      err_cnt_q    <= '0;
`endif
    end else begin
      // Plain two-flop synchronizer, no logic in between.
      s1_q <= gray_in;
      s2_q <= s1_q;
      if (prime_q != 2'd2) begin
        prime_q <= prime_q + 2'd1;
      end

      valid_q    <= 1'b0;
      wrap_q     <= 1'b0;
      step_err_q <= 1'b0;

      if (clear) begin
        // bin_out and dir_up hold until INIT reloads the baseline.
        state_q      <= ST_INIT;
        err_sticky_q <= 1'b0;
`ifdef GRAY_ERRCNT_EN
        err_cnt_q    <= '0;
`endif
      end else begin
        case (state_q)
          ST_INIT: begin
            prev_gray_q <= s2_q;
            bin_q       <= bin_d;
            // After reset, stay here until s2 has captured real input so a
            // non-zero bus at release cannot look like a step from zero.
            if (prime_q == 2'd2) begin
              state_q <= ST_TRACK;
            end
          end
          ST_TRACK: begin
            if (one_bit_d) begin
              valid_q     <= 1'b1;
              wrap_q      <= wrap_d;
              dir_up_q    <= dir_up_d;
              prev_gray_q <= s2_q;
              bin_q       <= bin_d;
            end else if (diff_d != '0) begin
              // Illegal jump: resync the baseline, infer no direction.
              step_err_q   <= 1'b1;
              err_sticky_q <= 1'b1;
              prev_gray_q  <= s2_q;
              bin_q        <= bin_d;
`ifdef GRAY_ERRCNT_EN
              if (err_cnt_q != CNT_MAX) begin
                err_cnt_q <= err_cnt_q + CNT_ONE;
              end
`endif
            end
          end
          default: state_q <= ST_INIT;
        endcase
      end
    end
  end

  assign bin_out    = bin_q;
  assign valid      = valid_q;
  assign dir_up     = dir_up_q;
  assign wrap       = wrap_q;
  assign step_err   = step_err_q;
  assign err_sticky = err_sticky_q;
`ifdef GRAY_ERRCNT_EN
  assign err_cnt    = err_cnt_q;
`endif

endmodule

// File: tb/tb_gray_decoder_monitor.sv
// Purpose: directed self-checking bench for gray_decoder_monitor (N=8, ERR_W=8).
// Latency: inputs change on the falling edge; outputs observed on falling edges.
// Backpressure: not applicable.
module tb_gray_decoder_monitor;

  logic       clk;
  logic       reset;
  logic       clear;
  logic [7:0] gray_in;
  logic [7:0] bin_out;
  logic       valid;
  logic       dir_up;
  logic       wrap;
  logic       step_err;
  logic       err_sticky;
`ifdef GRAY_ERRCNT_EN
  logic [7:0] err_cnt;
`endif

  gray_decoder_monitor #(.N(8), .ERR_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .gray_in    (gray_in),
    .bin_out    (bin_out),
    .valid      (valid),
    .dir_up     (dir_up),
    .wrap       (wrap),
    .step_err   (step_err),
    .err_sticky (err_sticky)
`ifdef GRAY_ERRCNT_EN
    ,
    .err_cnt    (err_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  int n_valid;
  int n_wrap;
  int n_err;
  int valid_at;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clr_counts();
    n_valid  = 0;
    n_wrap   = 0;
    n_err    = 0;
    valid_at = -1;
  endtask

  // Called at a falling edge: apply g, then observe for the given cycles.
  task automatic hold_gray(input logic [7:0] g, input int cycles);
    gray_in = g;
    for (int i = 1; i <= cycles; i++) begin
      @(negedge clk);
      if (valid) begin
        n_valid++;
        valid_at = i;
      end
      if (wrap)     n_wrap++;
      if (step_err) n_err++;
    end
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  logic [7:0] gseq [1:5];

  initial begin
    gseq[1] = 8'h01; gseq[2] = 8'h03; gseq[3] = 8'h02;
    gseq[4] = 8'h06; gseq[5] = 8'h07;

    reset   = 1'b0;
    clear   = 1'b0;
    gray_in = 8'h00;
    repeat (2) @(negedge clk);

    // 1: reset state and quiet baseline
    check("rst bin_out",    32'(bin_out), 32'h0);
    check("rst valid",      32'(valid), 32'h0);
    check("rst dir_up",     32'(dir_up), 32'h0);
    check("rst err_sticky", 32'(err_sticky), 32'h0);
`ifdef GRAY_ERRCNT_EN
    check("rst err_cnt",    32'(err_cnt), 32'h0);
`endif
    reset = 1'b1;
    clr_counts();
    hold_gray(8'h00, 6);
    check("t1 valid cnt", n_valid, 0);
    check("t1 err cnt",   n_err, 0);
    check("t1 bin_out",   32'(bin_out), 32'h0);

    // 2: count up 0..5, output lands 3 edges after each input change
    clr_counts();
    for (int b = 1; b <= 5; b++) begin
      valid_at = -1;
      hold_gray(gseq[b], 4);
      check("t2 valid latency", valid_at, 3);
    end
    check("t2 valid cnt", n_valid, 5);
    check("t2 bin_out",   32'(bin_out), 32'd5);
    check("t2 dir_up",    32'(dir_up), 32'h1);
    check("t2 wrap cnt",  n_wrap, 0);
    check("t2 err cnt",   n_err, 0);

    // 3: reach 255 via an illegal jump, clear, then wrap both ways
    clr_counts();
    hold_gray(8'h80, 4);
    check("t3 jump err",    n_err, 1);
    check("t3 jump bin",    32'(bin_out), 32'd255);
    pulse_clear();
    check("t3 clr sticky",  32'(err_sticky), 32'h0);
    check("t3 clr bin hold", 32'(bin_out), 32'd255);
    hold_gray(8'h80, 3);
    clr_counts();
    hold_gray(8'h00, 4);
    check("t3 up valid",  n_valid, 1);
    check("t3 up wrap",   n_wrap, 1);
    check("t3 up dir",    32'(dir_up), 32'h1);
    check("t3 up bin",    32'(bin_out), 32'd0);
    clr_counts();
    hold_gray(8'h80, 4);
    check("t3 dn valid",  n_valid, 1);
    check("t3 dn wrap",   n_wrap, 1);
    check("t3 dn dir",    32'(dir_up), 32'h0);
    check("t3 dn bin",    32'(bin_out), 32'd255);

    // 4: 1 -> 5 illegal, then legal 5 -> 4
    hold_gray(8'h00, 4);
    hold_gray(8'h01, 4);
    check("t4 bin before", 32'(bin_out), 32'd1);
    clr_counts();
    hold_gray(8'h07, 4);
    check("t4 err",      n_err, 1);
    check("t4 no valid", n_valid, 0);
    check("t4 no wrap",  n_wrap, 0);
    check("t4 sticky",   32'(err_sticky), 32'h1);
    check("t4 bin",      32'(bin_out), 32'd5);
`ifdef GRAY_ERRCNT_EN
    check("t4 err_cnt",  32'(err_cnt), 32'd1);
`endif
    clr_counts();
    hold_gray(8'h06, 4);
    check("t4 next valid", n_valid, 1);
    check("t4 next bin",   32'(bin_out), 32'd4);
    check("t4 next dir",   32'(dir_up), 32'h0);

    // 5: 300 illegal jumps, saturation, then clear
    clr_counts();
    for (int i = 0; i < 300; i++) begin
      hold_gray((i % 2 == 1) ? 8'h07 : 8'h00, (i == 299) ? 4 : 2);
    end
    check("t5 err pulses", n_err, 300);
    check("t5 sticky",     32'(err_sticky), 32'h1);
    check("t5 bin",        32'(bin_out), 32'd5);
`ifdef GRAY_ERRCNT_EN
    check("t5 err_cnt sat", 32'(err_cnt), 32'd255);
`endif
    pulse_clear();
    check("t5 clr sticky", 32'(err_sticky), 32'h0);
`ifdef GRAY_ERRCNT_EN
    check("t5 clr err_cnt", 32'(err_cnt), 32'd0);
`endif
    clr_counts();
    hold_gray(8'h07, 4);
    check("t5 init no valid", n_valid, 0);
    check("t5 init no err",   n_err, 0);
    check("t5 init bin",      32'(bin_out), 32'd5);
    clr_counts();
    hold_gray(8'h06, 4);
    check("t5 track valid", n_valid, 1);

    // 6: async reset while valid is high
    hold_gray(8'h00, 4);
    gray_in = 8'h01;
    repeat (3) @(negedge clk);
    check("t6 valid high", 32'(valid), 32'h1);
    check("t6 sticky pre", 32'(err_sticky), 32'h1);
    reset = 1'b0;
    #1;
    check("t6 rst bin",    32'(bin_out), 32'h0);
    check("t6 rst valid",  32'(valid), 32'h0);
    check("t6 rst dir",    32'(dir_up), 32'h0);
    check("t6 rst sticky", 32'(err_sticky), 32'h0);
`ifdef GRAY_ERRCNT_EN
    check("t6 rst err_cnt", 32'(err_cnt), 32'h0);
`endif
    repeat (2) @(negedge clk);
    reset = 1'b1;
    clr_counts();
    hold_gray(8'h01, 8);
    check("t6 no spur valid", n_valid, 0);
    check("t6 no spur err",   n_err, 0);
    check("t6 baseline bin",  32'(bin_out), 32'd1);
    clr_counts();
    hold_gray(8'h03, 4);
    check("t6 post valid", n_valid, 1);
    check("t6 post bin",   32'(bin_out), 32'd2);
    check("t6 post dir",   32'(dir_up), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
